// File: rtl/adder_result_collector_if.sv
// Handshake bundle between the pipelined adder, its issuer and the result consumer.
// The collector takes the slave view; the issuer/adder/consumer side takes the master view.
interface adder_result_collector_if #(
  parameter int SUM_W = 8,
  parameter int ACC_W = 16
);
  logic             issue;
  logic             issue_ok;
  logic             add_cout;
  logic [SUM_W-1:0] add_sum;
  logic             clr;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W:0]   res_data;
  logic [ACC_W-1:0] acc_out;
  logic             acc_wrap;
  logic             overflow;

  modport slave (
    input  issue, add_cout, add_sum, clr, res_ready,
    output issue_ok, res_valid, res_data, acc_out, acc_wrap, overflow
  );

  modport master (
    output issue, add_cout, add_sum, clr, res_ready,
    input  issue_ok, res_valid, res_data, acc_out, acc_wrap, overflow
  );
endinterface

// File: rtl/adder_result_collector.sv
// Collects {cout,sum} from a fixed-latency adder into a show-ahead FIFO,
// keeps a running accumulation and grants issue credit only when a slot is reserved.
module adder_result_collector #(
  parameter int SUM_W = 8,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  adder_result_collector_if.slave bus
);
  localparam int RW = SUM_W + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = CW + $clog2(LAT + 1) + 1;

  logic [LAT-1:0] vld;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [RW-1:0]  mem [DEPTH];
  logic [ACC_W-1:0] acc;
  logic           acc_wrap_q, overflow_q;

  logic           cap, pop, full, push_ok, drop;
  logic [RW-1:0]  res_word;
  logic [KW-1:0]  committed;
  logic [ACC_W:0] acc_sum;

  assign res_word = {bus.add_cout, bus.add_sum};
  assign cap      = vld[LAT-1];
  assign full     = (count == CW'(DEPTH));
  assign pop      = bus.res_valid & bus.res_ready;
  assign push_ok  = cap & (~full | pop);
  assign drop     = cap & full & ~pop;

  // Every stage of vld holds a result that already owns a slot, including the
  // one being captured now, so the credit never looks at this cycle's issue.
  always_comb begin
    committed = KW'(count);
    for (int i = 0; i < LAT; i++) committed = committed + KW'(vld[i]);
    if (pop) committed = committed - KW'(1);
  end

  assign bus.issue_ok  = (committed < KW'(DEPTH));
  assign bus.res_valid = (count != '0);
  assign bus.res_data  = mem[rd_ptr];
  assign bus.acc_out   = acc;
  assign bus.acc_wrap  = acc_wrap_q;
  assign bus.overflow  = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      vld <= {vld[LAT-2:0], bus.issue};
      if (push_ok) begin
        mem[wr_ptr] <= res_word;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(res_word);

  // Dropped results still count toward the accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      acc_wrap_q <= 1'b0;
    end else if (bus.clr) begin
      acc        <= cap ? ACC_W'(res_word) : '0;
      acc_wrap_q <= 1'b0;
    end else if (cap) begin
      acc        <= acc_sum[ACC_W-1:0];
      acc_wrap_q <= acc_wrap_q | acc_sum[ACC_W];
    end
  end
endmodule

// File: tb/tb_adder_result_collector.sv
// Randomized bench: models the 2-cycle adder and the collector at transaction level
// (result queue, in-flight list, plain-arithmetic accumulator) and compares every cycle.
module tb_adder_result_collector;
  localparam int SUM_W = 8;
  localparam int ACC_W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_result_collector_if #(.SUM_W(SUM_W), .ACC_W(ACC_W)) bus ();

  adder_result_collector #(.SUM_W(SUM_W), .LAT(2), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [8:0]  q[$];
  bit          pv[2];
  logic [8:0]  pd[2];
  int unsigned m_acc;
  bit          m_wrap, m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [8:0] add_of(input logic [7:0] a, input logic [7:0] b, input bit cin);
    return {1'b0, a} + {1'b0, b} + 9'(cin);
  endfunction

  function automatic bit credit(input bit rdy);
    int pending;
    bit pop;
    pending = int'(pv[0]) + int'(pv[1]);
    pop = (q.size() != 0) && rdy;
    return (q.size() + pending - int'(pop)) < DEPTH;
  endfunction

  // Called at posedge+1 (or mid-cycle after a reset); returns at the following posedge+1.
  task automatic step(input bit iss, input logic [7:0] a, input logic [7:0] b, input bit cin,
                      input bit rdy, input bit clr_i);
    logic [8:0] r;
    bit pop, cap, full, exp_ok;
    r = add_of(a, b, cin);
    bus.issue     = iss;
    bus.res_ready = rdy;
    bus.clr       = clr_i;
    bus.add_cout  = pd[1][8];
    bus.add_sum   = pd[1][7:0];
    exp_ok = credit(rdy);
    @(negedge clk);
    chk("issue_ok",  32'(bus.issue_ok),  32'(exp_ok));
    chk("res_valid", 32'(bus.res_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("res_data", 32'(bus.res_data), 32'(q[0]));
    chk("acc_out",   32'(bus.acc_out),   m_acc);
    chk("acc_wrap",  32'(bus.acc_wrap),  32'(m_wrap));
    chk("overflow",  32'(bus.overflow),  32'(m_ovf));
    cap  = pv[1];
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (full && !pop) m_ovf = 1'b1;
      else q.push_back(pd[1]);
    end
    if (clr_i) begin
      m_acc  = cap ? 32'(pd[1]) : 0;
      m_wrap = 1'b0;
    end else if (cap) begin
      m_acc = m_acc + 32'(pd[1]);
      if (m_acc >= 65536) begin
        m_acc  = m_acc - 65536;
        m_wrap = 1'b1;
      end
    end
    pv[1] = pv[0];
    pd[1] = pd[0];
    pv[0] = iss;
    pd[0] = iss ? r : 9'($urandom_range(0, 511));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  // Pulses reset inside one clock phase; the adder bus keeps delivering stale data.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_issue_ok",  32'(bus.issue_ok),  32'd1);
    chk("rst_acc_out",   32'(bus.acc_out),   32'd0);
    chk("rst_acc_wrap",  32'(bus.acc_wrap),  32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_acc = 0; m_wrap = 1'b0; m_ovf = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
  endtask

  initial begin
    int unsigned sum6;
    logic [7:0] a, b;
    bit cin, iss, rdy;
    rst_n = 1'b0;
    bus.issue = 1'b0; bus.res_ready = 1'b0; bus.clr = 1'b0;
    bus.add_cout = 1'b0; bus.add_sum = '0;
    pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
    m_acc = 0; m_wrap = 1'b0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // latency
    step(1'b1, 8'h0F, 8'h01, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("t1_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_data",  32'(bus.res_data),  32'h011);
    chk("t1_acc",   32'(bus.acc_out),   32'h0011);
    idle(1, 1'b1);

    // carry out
    step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("t2_data", 32'(bus.res_data), 32'h100);
    chk("t2_acc",  32'(bus.acc_out),  32'h0111);
    idle(1, 1'b1);

    // backpressure with credit honoured
    for (int i = 0; i < 10; i++) begin
      iss = credit(1'b0);
      step(iss, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    chk("t3_full_valid", 32'(bus.res_valid), 32'd1);
    chk("t3_no_ovf",     32'(bus.overflow),  32'd0);
    chk("t3_no_credit",  32'(bus.issue_ok),  32'd0);

    // full FIFO: capture and pop together, with clear
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("t5_acc",    32'(bus.acc_out),  32'h0046);
    chk("t5_no_ovf", 32'(bus.overflow), 32'd0);
    idle(6, 1'b1);

    // forced overflow
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    sum6 = 0;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      sum6 += 32'(add_of(a, b, cin));
      step(1'b1, a, b, cin, 1'b0, 1'b0);
    end
    idle(2, 1'b0);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    chk("t4_acc", 32'(bus.acc_out),  sum6);
    idle(6, 1'b1);

    // accumulator wrap
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 130; i++) step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("t6_acc",  32'(bus.acc_out),  32'((32'h1FE * 130) % 65536));
    chk("t6_wrap", 32'(bus.acc_wrap), 32'd1);

    // reset with two results in flight
    step(1'b1, 8'h55, 8'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h66, 8'h11, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(4, 1'b0);
    chk("t6_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("t6_rst_acc",   32'(bus.acc_out),   32'd0);

    // random traffic, mostly honouring credit
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      iss = ($urandom_range(0, 9) == 0) ? 1'b1 : (credit(rdy) && $urandom_range(0, 1) == 1);
      step(iss, 8'($urandom), 8'($urandom), 1'($urandom), rdy, $urandom_range(0, 30) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
